// File: rtl/reg_share_arbiter.sv
// Round-robin owner arbiter and write sequencer for one shared W-bit register.
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module reg_share_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 C,
  input  logic                 R,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         WE,
  input  logic [N*W-1:0]       DIN,
  output logic [N-1:0]         GNT,
  output logic [W-1:0]         Q,
  output logic                 BUSY,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 TO
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [N-1:0]    r_gnt;
  logic [W-1:0]    r_q;
  logic            r_busy;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_idx;
  logic [N-1:0]    w_onehot;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]   r_hold;
  logic            r_to;
`endif

  // First requester found walking upward from the slot after the last owner.
  always_comb begin
    w_found  = 1'b0;
    w_sel    = '0;
    w_idx    = r_ptr;
    w_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx == IW'(N - 1)) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + IW'(1);
      end
      if (!w_found && REQ[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_onehot[w_sel] = 1'b1;
  end

  // Ownership FSM; grant, busy, owner, timeout pulse and the shared register.
  always_ff @(posedge C) begin
    if (!R) begin
      r_state <= ST_IDLE;
      r_ptr   <= IW'(N - 1);
      r_owner <= '0;
      r_gnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= '0;
      r_to    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_to <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_owner <= w_sel;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // Write on the releasing edge is still honoured: state is GRANT here.
          if (WE[r_owner]) begin
            r_q <= DIN[r_owner*W +: W];
          end
          if (!REQ[r_owner]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_owner;
            r_state <= ST_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_hold == HW'(MAX_HOLD - 1)) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_owner;
            r_to    <= 1'b1;
            r_state <= ST_RELEASE;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
`endif
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT   = r_gnt;
  assign Q     = r_q;
  assign BUSY  = r_busy;
  assign OWNER = r_owner;
`ifdef ARB_TIMEOUT_EN
  assign TO    = r_to;
`else
  assign TO    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios plus random
// traffic compared against a behavioural owner/rotation model.
module tb_reg_share_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXH = 4;

  logic         clk;
  logic         rn;
  logic [3:0]   req;
  logic [3:0]   we;
  logic [31:0]  din;
  logic [3:0]   gnt;
  logic [7:0]   q;
  logic         busy;
  logic [1:0]   owner;
  logic         to_o;

  int n_vec;
  int n_err;

  // Model: who owns the register (-1 none), phase of the handshake, rotation point.
  int           m_own;
  int           m_last;
  int           m_ptr;
  int           m_phase;
  int           m_hold;
  logic         m_to;
  logic [7:0]   m_q;

  reg_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAXH)) dut (
    .C(clk), .R(rn), .REQ(req), .WE(we), .DIN(din),
    .GNT(gnt), .Q(q), .BUSY(busy), .OWNER(owner), .TO(to_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step;
    bit found;
    if (!rn) begin
      m_q = 8'h00; m_own = -1; m_last = 0; m_ptr = N - 1;
      m_phase = 0; m_hold = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_phase == 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!found && req[i]) begin
            found = 1'b1; m_own = i; m_last = i; m_phase = 1; m_hold = 0;
          end
        end
      end else if (m_phase == 1) begin
        if (we[m_own]) m_q = din[m_own*8 +: 8];
        if (!req[m_own]) begin
          m_ptr = m_own; m_own = -1; m_phase = 2;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_hold == MAXH - 1) begin
          m_ptr = m_own; m_own = -1; m_phase = 2; m_to = 1'b1;
        end else begin
          m_hold = m_hold + 1;
        end
`endif
      end else begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] e;
    e = 4'b0000;
    if (m_own >= 0) e[m_own] = 1'b1;
    return e;
  endfunction

  task automatic tick;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    req = 4'b0000; we = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic do_reset;
    rn = 1'b0; tick(); rn = 1'b1;
  endtask

  task automatic test_reset;
    rn = 1'b0; req = 4'b1111; we = 4'b1111; din = $urandom;
    repeat (2) tick();
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", q); end
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", owner); end
    n_vec++; if (to_o !== 1'b0) begin n_err++; $display("FAIL reset_to got %b want 0", to_o); end
    rn = 1'b1; we = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy got %b want 1", busy); end
    go_idle();
  endtask

  task automatic test_single_write;
    do_reset();
    req = 4'b0100; we = 4'b0000; din = 32'h0;
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", gnt); end
    n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL single_owner got %0d want 2", owner); end
    we = 4'b0100; din = 32'h00A5_0000;
    tick();
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL single_write got %h want a5", q); end
    we = 4'b0001; din = 32'h0011_003C;
    tick();
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL nonowner_write got %h want a5", q); end
    go_idle();
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL idle_keeps_q got %h want a5", q); end
  endtask

  task automatic test_rotation;
    int o;
    do_reset();
    req = 4'b1111; we = 4'b0000;
    tick();
    for (int g = 0; g < 5; g++) begin
      o = g % N;
      n_vec++; if (gnt !== 4'(1 << o)) begin n_err++; $display("FAIL rot_grant%0d got %b want %b", g, gnt, 4'(1 << o)); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rot_busy%0d got %b want 1", g, busy); end
      repeat (2) tick();
      req[o] = 1'b0;
      tick();
      n_vec++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL rot_gap1_%0d got %b/%b want 0000/0", g, gnt, busy); end
      req[o] = 1'b1;
      tick();
      n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rot_gap2_%0d got %b want 0000", g, gnt); end
      tick();
    end
    go_idle();
  endtask

  task automatic test_wrap;
    do_reset();
    req = 4'b1000; we = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_own3 got %b want 1000", gnt); end
    req = 4'b0000; repeat (2) tick();
    req = 4'b0101;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt0 got %b want 0001", gnt); end
    req = 4'b0100; tick();
    req = 4'b0101; tick();
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_gnt2 got %b want 0100", gnt); end
    n_vec++; if (owner !== 2'd2) begin n_err++; $display("FAIL wrap_owner got %0d want 2", owner); end
    go_idle();
  endtask

  task automatic test_reset_midgrant;
    do_reset();
    req = 4'b0010; we = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_gnt got %b want 0010", gnt); end
    we = 4'b0010; din = 32'h0000_5A00;
    tick();
    n_vec++; if (q !== 8'h5A) begin n_err++; $display("FAIL mid_write got %h want 5a", q); end
    rn = 1'b0; din = 32'h0000_FF00;
    tick();
    n_vec++; if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      n_err++; $display("FAIL mid_reset got q=%h gnt=%b busy=%b owner=%0d want 00/0000/0/0", q, gnt, busy, owner);
    end
    rn = 1'b1; we = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_regrant got %b want 0010", gnt); end
    go_idle();
  endtask

  task automatic test_timeout;
    int hi_cnt;
    int to_cnt;
    do_reset();
    req = 4'b0001; we = 4'b0000;
    hi_cnt = 0; to_cnt = 0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 20 && to_cnt == 0; c++) begin
      tick();
      if (gnt[0]) hi_cnt++;
      if (to_o) to_cnt++;
    end
    n_vec++; if (to_cnt !== 1) begin n_err++; $display("FAIL to_seen got %0d want 1", to_cnt); end
    n_vec++; if (hi_cnt !== MAXH) begin n_err++; $display("FAIL to_hold got %0d want %0d", hi_cnt, MAXH); end
    req = 4'b0011;
    tick();
    n_vec++; if (to_o !== 1'b0) begin n_err++; $display("FAIL to_pulse_len got %b want 0", to_o); end
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL to_next got %b want 0010", gnt); end
`else
    for (int c = 0; c < 55; c++) begin
      tick();
      if (gnt === 4'b0001) hi_cnt++;
      if (to_o !== 1'b0) to_cnt++;
    end
    n_vec++; if (hi_cnt !== 55) begin n_err++; $display("FAIL hold_forever got %0d want 55", hi_cnt); end
    n_vec++; if (to_cnt !== 0) begin n_err++; $display("FAIL to_const got %0d want 0", to_cnt); end
`endif
    go_idle();
  endtask

  task automatic test_random;
    do_reset();
    req = 4'b0000; we = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      rn = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      we  = 4'($urandom);
      din = $urandom;
      tick();
      n_vec++;
      if (gnt !== exp_gnt() || q !== m_q || busy !== (m_own >= 0) ||
          owner !== 2'(m_last) || to_o !== m_to) begin
        n_err++;
        $display("FAIL rand_cyc%0d got gnt=%b q=%h busy=%b own=%0d to=%b want gnt=%b q=%h busy=%b own=%0d to=%b",
                 c, gnt, q, busy, owner, to_o, exp_gnt(), m_q, (m_own >= 0), m_last, m_to);
      end
    end
    rn = 1'b1;
    go_idle();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_own = -1; m_last = 0; m_ptr = N - 1; m_phase = 0; m_hold = 0; m_to = 1'b0; m_q = 8'h00;
    rn = 1'b0; req = 4'b0000; we = 4'b0000; din = 32'h0;
    test_reset();
    test_single_write();
    test_rotation();
    test_wrap();
    test_reset_midgrant();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and write sequencer that shares one W-bit D-flip-flop register among N requesters. It grants exclusive ownership with a REQ/GNT handshake and writes the owner's data slice into the shared register on owner write strobes. The shared register is exposed as Q for downstream lab logic. It sits between the requesting lab modules and the register bank, and it is the only writer of that bank.

## Interface
- N, 4: number of requesters, 2..8.
- W, 8: shared register width.
- MAX_HOLD, 16: maximum grant length in cycles. Used only with the timeout feature.

- C  in  1  clock; all state updates on posedge C.
- R  in  1  synchronous reset, active-low; sampled on posedge C.
- REQ  in  N  request per requester; level, held while ownership is wanted.
- WE  in  N  write strobe per requester; honoured only for the current owner.
- DIN  in  N*W  packed write data; requester i uses bits [i*W +: W].
- GNT  out  N  one-hot grant, registered; all-zero when no owner.
- Q  out  W  shared register contents.
- BUSY  out  1  high while state is GRANT.
- OWNER  out  $clog2(N)  index of the current or last owner.
- TO  out  1  one-cycle pulse on a forced release; constant 0 without the timeout feature.

## Operation
- States:
  - IDLE: if any REQ bit is set, select the first set bit searching upward from (PTR+1) mod N, wrapping around. Load GNT one-hot, load OWNER, go to GRANT. If no REQ bit is set, stay in IDLE.
  - GRANT: if WE[OWNER] is high, Q <= DIN slice OWNER. If REQ[OWNER] is low, clear GNT, set PTR <= OWNER, go to RELEASE.
  - RELEASE: GNT stays 0; always go to IDLE (turnaround cycle).
- Writes:
  - Non-owner WE bits are ignored in every state.
  - No writes occur in IDLE or RELEASE.
  - A write with WE and REQ both dropping on the same edge is still accepted, because the state is GRANT at that edge.
- Requests:
  - A non-owner's REQ changes during GRANT have no effect until the next IDLE arbitration.
  - REQ pulses shorter than one sampled edge in IDLE are lost; there is no request latching.
- Reset (R low at an edge), from any state, including mid-grant:
  - Q=0, GNT=0, BUSY=0, OWNER=0, TO=0, state=IDLE.
  - PTR=N-1, so requester 0 wins first.
  - Hold counter=0.
  - Reset has priority over any write in the same cycle.

## Timing
- Grant latency: REQ high, sampled in IDLE at edge k, gives GNT high after edge k.
- First write: at earliest at edge k+1, with Q updated after that edge.
- Write latency: one edge from WE to Q.
- Release: REQ[OWNER] low sampled at edge m clears GNT after edge m. The next grant is visible after edge m+2 at the earliest, so GNT is all-zero for exactly 2 cycles between back-to-back owners.
- BUSY equals OR of GNT, cycle-exact.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 grants.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter resets to 0 on entry to GRANT and increments each GRANT cycle.
  - At the edge where the counter equals MAX_HOLD-1 and REQ[OWNER] is still high, the block forces the RELEASE transition: GNT clears, PTR <= OWNER, TO pulses high for that one cycle.
  - A WE on that edge is still written.
  - The preempted requester re-arbitrates normally and goes behind the others in rotation.
- Undefined:
  - No counter; ownership lasts until REQ drops.
  - TO tied 0; MAX_HOLD ignored.

## Test plan
- Reset: drive R=0 for 2 edges with REQ=4'b1111 and WE=4'b1111 → Q=8'h00, GNT=0, BUSY=0, OWNER=0; after R=1, the first GNT is 4'b0001.
- Single owner write: REQ=4'b0100, then WE[2] with DIN slice 2=8'hA5 → GNT=4'b0100 one edge after REQ; Q=8'hA5 one edge after WE; WE[0] with slice 0=8'h3C leaves Q=8'hA5.
- Rotation: hold REQ=4'b1111, each owner drops REQ after 3 cycles then re-raises it → grant order 0,1,2,3,0 with exactly 2 zero-GNT cycles between grants.
- Wrap-around and pointer: last owner 3, then REQ=4'b0101 in IDLE → GNT=4'b0001; next arbitration with REQ=4'b0101 → GNT=4'b0100.
- Reset mid-grant: owner 1 writes 8'h5A, then R=0 while GNT=4'b0010 and WE[1] is high → Q=0, GNT=0, state IDLE; after release, REQ=4'b0010 is granted one edge later.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: REQ[0] held high → GNT[0] high for exactly 4 cycles, TO=1 for one cycle, then with REQ=4'b0011 the next grant is 4'b0010. Without the macro, GNT[0] stays high for 50+ cycles and TO stays 0.
